// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter_if                                                      |
// | Fetch, data and shared bus signals of the memory port arbiter.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  // fetch requester
  logic                  if_req_i;
  logic [ADDR_W-1:0]     if_addr_i;
  logic                  if_rvalid_o;
  logic [DATA_W-1:0]     if_rdata_o;
  logic                  if_stall_o;
  // data requester
  logic                  d_rd_i;
  logic                  d_wr_i;
  logic [ADDR_W-1:0]     d_addr_i;
  logic [DATA_W-1:0]     d_wdata_i;
  logic [DATA_W/8-1:0]   d_be_i;
  logic                  d_rvalid_o;
  logic [DATA_W-1:0]     d_rdata_o;
  logic                  d_stall_o;
  // shared bus
  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [ADDR_W-1:0]     bus_addr_o;
  logic [DATA_W-1:0]     bus_wdata_o;
  logic [DATA_W/8-1:0]   bus_be_o;
  logic                  bus_gnt_i;
  logic                  bus_rvalid_i;
  logic [DATA_W-1:0]     bus_rdata_i;

  modport master (
    input  if_req_i, if_addr_i,
    input  d_rd_i, d_wr_i, d_addr_i, d_wdata_i, d_be_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output if_rvalid_o, if_rdata_o, if_stall_o,
    output d_rvalid_o, d_rdata_o, d_stall_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    output d_rd_i, d_wr_i, d_addr_i, d_wdata_i, d_be_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  if_rvalid_o, if_rdata_o, if_stall_o,
    input  d_rvalid_o, d_rdata_o, d_stall_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one single-outstanding bus port between fetch and data ports.    |
// | Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  mem_port_arbiter_if.master port
);

  localparam int   BE_W   = DATA_W / 8;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner;
  logic                w_owner_nxt;
  logic                r_bus_req;
  logic                w_bus_req_nxt;
  logic                r_we;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic [BE_W-1:0]     r_be;
  logic [BE_W-1:0]     w_be_nxt;

  logic                w_if_pend;
  logic                w_d_pend;
  logic                w_grant_d;
  logic                w_done;

  assign w_if_pend = port.if_req_i;
  assign w_d_pend  = port.d_rd_i | port.d_wr_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_owner;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_last_owner <= OWN_IF;
    end else if (w_done) begin
      r_last_owner <= r_owner;
    end
  end

  // On contention the requester that was not served last takes the bus.
  assign w_grant_d = w_d_pend & (~w_if_pend | (r_last_owner == OWN_IF));
`else
  assign w_grant_d = w_d_pend;
`endif

  // Response accepted in REQ together with gnt, or any time in WAIT; a cycle
  // held in reset never completes a transaction.
  assign w_done = rst_n_i &
                  (((r_state == ST_REQ) & port.bus_gnt_i & port.bus_rvalid_i) |
                   ((r_state == ST_WAIT) & port.bus_rvalid_i));

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_bus_req_nxt = r_bus_req;
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_be_nxt      = r_be;

    case (r_state)
      ST_IDLE: begin
        if (w_if_pend | w_d_pend) begin
          w_state_nxt   = ST_REQ;
          w_bus_req_nxt = 1'b1;
          if (w_grant_d) begin
            w_owner_nxt = OWN_D;
            w_we_nxt    = port.d_wr_i;
            w_addr_nxt  = port.d_addr_i;
            w_wdata_nxt = port.d_wdata_i;
            w_be_nxt    = port.d_be_i;
          end else begin
            w_owner_nxt = OWN_IF;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = port.if_addr_i;
            w_wdata_nxt = '0;
            w_be_nxt    = '1;
          end
        end
      end
      ST_REQ: begin
        if (port.bus_gnt_i) begin
          w_bus_req_nxt = 1'b0;
          w_state_nxt   = port.bus_rvalid_i ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (port.bus_rvalid_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_bus_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_IF;
      r_bus_req <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_bus_req <= w_bus_req_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_be      <= w_be_nxt;
    end
  end

  assign port.bus_req_o   = r_bus_req;
  assign port.bus_we_o    = r_we;
  assign port.bus_addr_o  = r_addr;
  assign port.bus_wdata_o = r_wdata;
  assign port.bus_be_o    = r_be;

  assign port.if_rvalid_o = w_done & (r_owner == OWN_IF);
  assign port.d_rvalid_o  = w_done & (r_owner == OWN_D);
  assign port.if_rdata_o  = port.if_rvalid_o ? port.bus_rdata_i : '0;
  assign port.d_rdata_o   = port.d_rvalid_o  ? port.bus_rdata_i : '0;

  assign port.if_stall_o  = w_if_pend & ~port.if_rvalid_o;
  assign port.d_stall_o   = w_d_pend  & ~port.d_rvalid_o;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                      |
// | Directed and randomized checks of mem_port_arbiter against a            |
// | transaction-level model. Revision: 1.0                                   |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int OUT_W  = ADDR_W + 3 * DATA_W + BE_W + 6;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  bit   model_last_d = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .port    (u_if.master)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [OUT_W-1:0] all_outs();
    return {u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_o, u_if.bus_wdata_o,
            u_if.bus_be_o, u_if.if_rvalid_o, u_if.if_rdata_o, u_if.if_stall_o,
            u_if.d_rvalid_o, u_if.d_rdata_o, u_if.d_stall_o};
  endfunction

  // Expected winner from the arbitration rules (1 = data port).
  function automatic bit pick_d(bit ifp, bit dp);
    if (!ifp) return 1'b1;
    if (!dp)  return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return !model_last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.if_req_i     = 1'b0;
    u_if.if_addr_i    = '0;
    u_if.d_rd_i       = 1'b0;
    u_if.d_wr_i       = 1'b0;
    u_if.d_addr_i     = '0;
    u_if.d_wdata_i    = '0;
    u_if.d_be_i       = '0;
    u_if.bus_gnt_i    = 1'b0;
    u_if.bus_rvalid_i = 1'b0;
    u_if.bus_rdata_i  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n_i = 1'b0;
    step();
    step();
    rst_n_i = 1'b1;
    model_last_d = 1'b0;
  endtask

  task automatic new_if_req();
    u_if.if_req_i  = ($urandom_range(0, 3) != 0);
    u_if.if_addr_i = $urandom & ~32'h3;
  endtask

  task automatic new_d_req();
    int op;
    op = $urandom_range(0, 3);
    u_if.d_rd_i    = op[0];
    u_if.d_wr_i    = op[1];
    u_if.d_addr_i  = $urandom;
    u_if.d_wdata_i = $urandom;
    u_if.d_be_i    = BE_W'($urandom_range(0, (1 << BE_W) - 1));
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++;
      $display("FAIL reset_outs got %h exp 0", all_outs());
    end
  endtask

  task automatic test_fetch();
    apply_reset();
    u_if.if_req_i  = 1'b1;
    u_if.if_addr_i = 32'h100;
    #1;
    n_cmp++;
    if ({u_if.bus_req_o, u_if.if_stall_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL fetch_idle got %b exp 01", {u_if.bus_req_o, u_if.if_stall_o});
    end
    step();
    u_if.bus_gnt_i = 1'b1;
    #1;
    n_cmp++;
    if ({u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_o, u_if.bus_be_o, u_if.if_rvalid_o}
        !== {1'b1, 1'b0, 32'h100, 4'hF, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_req req=%b we=%b addr=%h be=%h rv=%b exp 1 0 100 f 0",
               u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_o, u_if.bus_be_o, u_if.if_rvalid_o);
    end
    step();
    u_if.bus_gnt_i    = 1'b0;
    u_if.bus_rvalid_i = 1'b1;
    u_if.bus_rdata_i  = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if ({u_if.if_rvalid_o, u_if.if_rdata_o, u_if.if_stall_o, u_if.d_rvalid_o}
        !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_done rv=%b rdata=%h stall=%b drv=%b exp 1 deadbeef 0 0",
               u_if.if_rvalid_o, u_if.if_rdata_o, u_if.if_stall_o, u_if.d_rvalid_o);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if ({u_if.if_rvalid_o, u_if.if_rdata_o, u_if.bus_req_o} !== {1'b0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_after rv=%b rdata=%h req=%b exp 0 0 0",
               u_if.if_rvalid_o, u_if.if_rdata_o, u_if.bus_req_o);
    end
  endtask

  task automatic test_store();
    u_if.d_wr_i    = 1'b1;
    u_if.d_addr_i  = 32'h2000;
    u_if.d_wdata_i = 32'h55;
    u_if.d_be_i    = 4'h1;
    #1;
    n_cmp++;
    if ({u_if.d_stall_o, u_if.d_rvalid_o, u_if.bus_req_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL store_idle got %b exp 100", {u_if.d_stall_o, u_if.d_rvalid_o, u_if.bus_req_o});
    end
    step();
    u_if.bus_gnt_i    = 1'b1;
    u_if.bus_rvalid_i = 1'b1;
    u_if.bus_rdata_i  = 32'h0;
    #1;
    n_cmp++;
    if ({u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_o, u_if.bus_wdata_o, u_if.bus_be_o}
        !== {1'b1, 1'b1, 32'h2000, 32'h55, 4'h1}) begin
      n_bad++;
      $display("FAIL store_bus req=%b we=%b addr=%h wdata=%h be=%h exp 1 1 2000 55 1",
               u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_o, u_if.bus_wdata_o, u_if.bus_be_o);
    end
    n_cmp++;
    if ({u_if.d_rvalid_o, u_if.d_stall_o, u_if.if_rvalid_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL store_done got %b exp 100", {u_if.d_rvalid_o, u_if.d_stall_o, u_if.if_rvalid_o});
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if ({u_if.d_rvalid_o, u_if.d_stall_o, u_if.bus_req_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL store_after got %b exp 000", {u_if.d_rvalid_o, u_if.d_stall_o, u_if.bus_req_o});
    end
  endtask

  task automatic test_rd_wr_both();
    u_if.d_rd_i   = 1'b1;
    u_if.d_wr_i   = 1'b1;
    u_if.d_addr_i = 32'h44;
    step();
    u_if.bus_gnt_i    = 1'b1;
    u_if.bus_rvalid_i = 1'b1;
    #1;
    n_cmp++;
    if ({u_if.bus_req_o, u_if.bus_we_o, u_if.d_rvalid_o} !== 3'b111) begin
      n_bad++;
      $display("FAIL rdwr_we got %b exp 111", {u_if.bus_req_o, u_if.bus_we_o, u_if.d_rvalid_o});
    end
    step();
    idle_inputs();
  endtask

  task automatic test_contention();
    logic [3:0] got;
    logic [3:0] exp_g;
    int n;
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = 4'b1010;
`else
    exp_g = 4'b1111;
`endif
    got = '0;
    n = 0;
    apply_reset();
    u_if.if_req_i  = 1'b1;
    u_if.if_addr_i = 32'h300;
    u_if.d_rd_i    = 1'b1;
    u_if.d_addr_i  = 32'h400;
    for (int cyc = 0; cyc < 24 && n < 4; cyc++) begin
      u_if.bus_gnt_i    = u_if.bus_req_o;
      u_if.bus_rvalid_i = u_if.bus_req_o;
      u_if.bus_rdata_i  = $urandom;
      #1;
      if (u_if.if_rvalid_o && u_if.d_rvalid_o) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cont_both_rvalid cycle %0d got 11 exp one-hot", cyc);
      end
      if (u_if.if_rvalid_o || u_if.d_rvalid_o) begin
        got[3-n] = u_if.d_rvalid_o;
        n++;
      end
      step();
    end
    idle_inputs();
    n_cmp++;
    if (n !== 4) begin
      n_bad++;
      $display("FAIL cont_count got %0d exp 4", n);
    end
    n_cmp++;
    if (got !== exp_g) begin
      n_bad++;
      $display("FAIL cont_order got %b exp %b (1=D)", got, exp_g);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    u_if.d_rd_i   = 1'b1;
    u_if.d_addr_i = 32'h3000;
    step();
    u_if.bus_gnt_i = 1'b1;
    step();
    u_if.bus_gnt_i = 1'b0;
    #1;
    n_cmp++;
    if ({u_if.bus_req_o, u_if.d_rvalid_o, u_if.d_stall_o} !== 3'b001) begin
      n_bad++;
      $display("FAIL rstw_wait got %b exp 001", {u_if.bus_req_o, u_if.d_rvalid_o, u_if.d_stall_o});
    end
    rst_n_i       = 1'b0;
    u_if.d_rd_i   = 1'b0;
    step();
    rst_n_i = 1'b1;
    u_if.bus_rvalid_i = 1'b1;
    u_if.bus_rdata_i  = 32'h12345678;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++;
      $display("FAIL rstw_late_rvalid got %h exp 0", all_outs());
    end
    step();
    u_if.bus_rvalid_i = 1'b0;
    u_if.if_req_i     = 1'b1;
    u_if.if_addr_i    = 32'h500;
    #1;
    n_cmp++;
    if ({u_if.bus_req_o, u_if.if_rvalid_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL rstw_idle got %b exp 00", {u_if.bus_req_o, u_if.if_rvalid_o});
    end
    step();
    u_if.bus_gnt_i    = 1'b1;
    u_if.bus_rvalid_i = 1'b1;
    #1;
    n_cmp++;
    if ({u_if.bus_req_o, u_if.bus_addr_o, u_if.if_rvalid_o} !== {1'b1, 32'h500, 1'b1}) begin
      n_bad++;
      $display("FAIL rstw_recover req=%b addr=%h rv=%b exp 1 500 1",
               u_if.bus_req_o, u_if.bus_addr_o, u_if.if_rvalid_o);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_spurious();
    apply_reset();
    u_if.bus_rvalid_i = 1'b1;
    u_if.bus_rdata_i  = 32'hCAFEF00D;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++;
      $display("FAIL spurious_idle got %h exp 0", all_outs());
    end
    step();
    idle_inputs();
  endtask

  task automatic test_random();
    bit ifp, dp, win_d;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata, exp_rdata;
    logic [BE_W-1:0]   exp_be;
    logic              exp_we;
    int gdel, rdel;
    apply_reset();
    new_if_req();
    new_d_req();
    if (!(u_if.if_req_i || u_if.d_rd_i || u_if.d_wr_i)) u_if.if_req_i = 1'b1;
    for (int t = 0; t < 60; t++) begin
      ifp       = u_if.if_req_i;
      dp        = u_if.d_rd_i | u_if.d_wr_i;
      win_d     = pick_d(ifp, dp);
      exp_addr  = win_d ? u_if.d_addr_i : u_if.if_addr_i;
      exp_we    = win_d & u_if.d_wr_i;
      exp_be    = win_d ? u_if.d_be_i : {BE_W{1'b1}};
      exp_wdata = u_if.d_wdata_i;
      u_if.bus_gnt_i    = 1'b0;
      u_if.bus_rvalid_i = $urandom_range(0, 1);
      u_if.bus_rdata_i  = $urandom;
      #1;
      n_cmp++;
      if ({u_if.bus_req_o, u_if.if_rvalid_o, u_if.d_rvalid_o, u_if.if_stall_o, u_if.d_stall_o}
          !== {3'b000, ifp, dp}) begin
        n_bad++;
        $display("FAIL rnd_idle t=%0d got %b exp %b", t,
                 {u_if.bus_req_o, u_if.if_rvalid_o, u_if.d_rvalid_o, u_if.if_stall_o, u_if.d_stall_o},
                 {3'b000, ifp, dp});
      end
      step();
      gdel = $urandom_range(0, 2);
      rdel = $urandom_range(0, 2);
      for (int k = 0; k <= gdel; k++) begin
        u_if.bus_gnt_i    = (k == gdel);
        u_if.bus_rvalid_i = (k == gdel) ? (rdel == 0) : 1'($urandom_range(0, 1));
        exp_rdata         = $urandom;
        u_if.bus_rdata_i  = exp_rdata;
        #1;
        n_cmp++;
        if ({u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_o, u_if.bus_be_o}
            !== {1'b1, exp_we, exp_addr, exp_be} ||
            (win_d && u_if.bus_wdata_o !== exp_wdata)) begin
          n_bad++;
          $display("FAIL rnd_bus t=%0d got %b %b %h %h %h exp 1 %b %h %h %h", t,
                   u_if.bus_req_o, u_if.bus_we_o, u_if.bus_addr_o, u_if.bus_be_o, u_if.bus_wdata_o,
                   exp_we, exp_addr, exp_be, exp_wdata);
        end
        if (k != gdel || rdel != 0) begin
          n_cmp++;
          if ({u_if.if_rvalid_o, u_if.d_rvalid_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL rnd_early_rvalid t=%0d got %b exp 00", t, {u_if.if_rvalid_o, u_if.d_rvalid_o});
          end
          step();
        end
      end
      if (rdel != 0) begin
        u_if.bus_gnt_i = 1'b0;
        for (int k = 1; k < rdel; k++) begin
          u_if.bus_rvalid_i = 1'b0;
          u_if.bus_rdata_i  = $urandom;
          #1;
          n_cmp++;
          if ({u_if.bus_req_o, u_if.if_rvalid_o, u_if.d_rvalid_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL rnd_wait t=%0d got %b exp 000", t,
                     {u_if.bus_req_o, u_if.if_rvalid_o, u_if.d_rvalid_o});
          end
          step();
        end
        u_if.bus_rvalid_i = 1'b1;
        exp_rdata         = $urandom;
        u_if.bus_rdata_i  = exp_rdata;
        #1;
      end
      n_cmp++;
      if ({u_if.if_rvalid_o, u_if.if_rdata_o, u_if.d_rvalid_o, u_if.d_rdata_o}
          !== (win_d ? {1'b0, 32'h0, 1'b1, exp_rdata} : {1'b1, exp_rdata, 1'b0, 32'h0})) begin
        n_bad++;
        $display("FAIL rnd_done t=%0d got if %b %h d %b %h exp winner_d=%b rdata %h", t,
                 u_if.if_rvalid_o, u_if.if_rdata_o, u_if.d_rvalid_o, u_if.d_rdata_o, win_d, exp_rdata);
      end
      n_cmp++;
      if ({u_if.if_stall_o, u_if.d_stall_o} !== {ifp & win_d, dp & ~win_d}) begin
        n_bad++;
        $display("FAIL rnd_stall t=%0d got %b exp %b", t,
                 {u_if.if_stall_o, u_if.d_stall_o}, {ifp & win_d, dp & ~win_d});
      end
      step();
      u_if.bus_gnt_i    = 1'b0;
      u_if.bus_rvalid_i = 1'b0;
      model_last_d      = win_d;
      if (win_d) new_d_req();
      else       new_if_req();
      if (!(u_if.if_req_i || u_if.d_rd_i || u_if.d_wr_i)) u_if.if_req_i = 1'b1;
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_rd_wr_both();
    test_contention();
    test_reset_in_wait();
    test_spurious();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
